// File: rtl/add_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a ripple carry register.
// Latency: done pulses WIDTH/CHUNK cycles after the accepted start edge.
// Backpressure: start is ignored while busy; there is no queuing, so the caller must wait for busy=0.
module add_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int IDXW  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(STEPS - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("add_seq: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CHUNK:0]   sum;
    logic             last;
    int               base;

    assign busy = (state_q == RUN);
    assign last = (idx == LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        base = int'(idx) * CHUNK;
        sum  = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]} + {{CHUNK{1'b0}}, carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            out     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    // Subtraction is A + ~B + 1, so the carry register seeds the +1.
                    a_q   <= num1;
                    b_q   <= sub ? ~num2 : num2;
                    carry <= sub ? 1'b1 : cin;
                    idx   <= '0;
                end
            end else begin
                out[base +: CHUNK] <= sum[CHUNK-1:0];
                carry              <= sum[CHUNK];
                idx                <= idx + IDXW'(1);
                if (last) begin
                    idx  <= '0;
                    cout <= sum[CHUNK];
                    ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_add_seq.sv
// Directed bench for add_seq at 8/2, plus exhaustive 4-bit sweeps on 4/4 and 4/1 instances.
module tb_add_seq;

    logic clk;
    logic rst;

    logic       s8_start, s8_sub, s8_cin;
    logic [7:0] s8_a, s8_b;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] out8;

    logic       s4_start, s4_sub, s4_cin;
    logic [3:0] s4_a, s4_b;
    logic       busy44, done44, cout44, ovf44;
    logic [3:0] out44;
    logic       busy41, done41, cout41, ovf41;
    logic [3:0] out41;

    int n_chk  = 0;
    int n_pass = 0;

    add_seq #(.WIDTH(8), .CHUNK(2)) d8 (
        .clk(clk), .rst(rst), .start(s8_start), .sub(s8_sub), .cin(s8_cin),
        .num1(s8_a), .num2(s8_b), .busy(busy8), .done(done8), .out(out8),
        .cout(cout8), .ovf(ovf8)
    );

    add_seq #(.WIDTH(4), .CHUNK(4)) d44 (
        .clk(clk), .rst(rst), .start(s4_start), .sub(s4_sub), .cin(s4_cin),
        .num1(s4_a), .num2(s4_b), .busy(busy44), .done(done44), .out(out44),
        .cout(cout44), .ovf(ovf44)
    );

    add_seq #(.WIDTH(4), .CHUNK(1)) d41 (
        .clk(clk), .rst(rst), .start(s4_start), .sub(s4_sub), .cin(s4_cin),
        .num1(s4_a), .num2(s4_b), .busy(busy41), .done(done41), .out(out41),
        .cout(cout41), .ovf(ovf41)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic issue8(input logic sub, input logic cin, input logic [7:0] a, input logic [7:0] b);
        s8_sub   = sub;
        s8_cin   = cin;
        s8_a     = a;
        s8_b     = b;
        s8_start = 1'b1;
        @(negedge clk);
        s8_start = 1'b0;
    endtask

    // Called one negedge after the start edge; returns at the negedge where done is high.
    task automatic finish8(input string tag, input logic disturb,
                           input logic [7:0] eo, input logic ec, input logic ev);
        int lat;
        int bcnt;
        lat  = 1;
        bcnt = 0;
        if (disturb) begin
            s8_start = 1'b1;
            s8_sub   = ~s8_sub;
            s8_cin   = ~s8_cin;
            s8_a     = 8'hAA;
            s8_b     = 8'hFF;
        end
        while (!done8 && lat <= 20) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
        s8_start = 1'b0;
        check({tag, " latency"}, lat, 5);
        check({tag, " busy cycles"}, bcnt, 4);
        check({tag, " busy at done"}, busy8, 1'b0);
        check({tag, " out"}, out8, eo);
        check({tag, " cout"}, cout8, ec);
        check({tag, " ovf"}, ovf8, ev);
    endtask

    task automatic run8(input string tag, input logic sub, input logic cin,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eo, input logic ec, input logic ev, input logic disturb);
        issue8(sub, cin, a, b);
        finish8(tag, disturb, eo, ec, ev);
        @(negedge clk);
        check({tag, " done one cycle"}, done8, 1'b0);
    endtask

    function automatic logic [5:0] model4(input logic sub, input logic cin,
                                          input logic [3:0] a, input logic [3:0] b);
        int ua, ub, sa, sb, r, u;
        logic [3:0] o;
        logic c, v;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            u = ua - ub;
            c = (ua >= ub);
            r = sa - sb;
        end else begin
            u = ua + ub + int'(cin);
            c = (u > 15);
            r = sa + sb + int'(cin);
        end
        o = u[3:0];
        v = (r > 7) || (r < -8);
        return {v, c, o};
    endfunction

    task automatic run4(input string tag, input logic sub, input logic cin,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] eo, input logic ec, input logic ev);
        int lat, l44, l41;
        s4_sub   = sub;
        s4_cin   = cin;
        s4_a     = a;
        s4_b     = b;
        s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        lat = 1;
        l44 = 0;
        l41 = 0;
        while ((l44 == 0 || l41 == 0) && lat <= 10) begin
            if (done44 && l44 == 0) l44 = lat;
            if (done41 && l41 == 0) l41 = lat;
            if (l44 == 0 || l41 == 0) begin
                @(negedge clk);
                lat++;
            end
        end
        check({tag, " 4/4 latency"}, l44, 2);
        check({tag, " 4/1 latency"}, l41, 5);
        check({tag, " 4/4 out"}, out44, eo);
        check({tag, " 4/4 cout"}, cout44, ec);
        check({tag, " 4/4 ovf"}, ovf44, ev);
        check({tag, " 4/1 out"}, out41, eo);
        check({tag, " 4/1 cout"}, cout41, ec);
        check({tag, " 4/1 ovf"}, ovf41, ev);
    endtask

    initial begin
        logic [5:0] m;
        logic [7:0] iv;
        logic       rc;
        int         dn;

        rst = 1'b1;
        s8_start = 1'b0; s8_sub = 1'b0; s8_cin = 1'b0; s8_a = 8'h00; s8_b = 8'h00;
        s4_start = 1'b0; s4_sub = 1'b0; s4_cin = 1'b0; s4_a = 4'h0; s4_b = 4'h0;
        repeat (3) @(negedge clk);
        check("reset busy", busy8, 1'b0);
        check("reset done", done8, 1'b0);
        check("reset out", out8, 8'h00);
        check("reset cout", cout8, 1'b0);
        check("reset ovf", ovf8, 1'b0);
        check("reset 4/1 busy", busy41, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run8("0+0",      1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        run8("FF+01",    1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        run8("7F+01",    1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run8("10+20+1",  1'b0, 1'b1, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0);
        run8("05-07",    1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
        run8("80-01",    1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        run8("0A-0A",    1'b1, 1'b0, 8'h0A, 8'h0A, 8'h00, 1'b1, 1'b0, 1'b0);
        run8("disturb",  1'b0, 1'b0, 8'h3C, 8'h41, 8'h7D, 1'b0, 1'b0, 1'b1);

        // Second start lands on the done cycle of the first.
        issue8(1'b0, 1'b0, 8'h12, 8'h34);
        finish8("b2b first", 1'b0, 8'h46, 1'b0, 1'b0);
        issue8(1'b1, 1'b0, 8'h40, 8'h50);
        check("b2b done falls", done8, 1'b0);
        check("b2b busy", busy8, 1'b1);
        finish8("b2b second", 1'b0, 8'hF0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset two cycles into an operation aborts it.
        issue8(1'b0, 1'b0, 8'hC8, 8'h64);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", busy8, 1'b0);
        check("abort out", out8, 8'h00);
        check("abort cout", cout8, 1'b0);
        dn = 0;
        repeat (8) begin
            if (done8) dn++;
            @(negedge clk);
        end
        check("abort no done", dn, 0);

        run4("15+15", 1'b0, 1'b0, 4'd15, 4'd15, 4'd14, 1'b1, 1'b0);
        run4("10+5",  1'b0, 1'b0, 4'd10, 4'd5,  4'd15, 1'b0, 1'b0);
        run4("15+1",  1'b0, 1'b0, 4'd15, 4'd1,  4'd0,  1'b1, 1'b0);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) begin
                iv = i[7:0];
                rc = ($urandom_range(0, 1) == 1);
                m  = model4(s[0], rc, iv[7:4], iv[3:0]);
                run4($sformatf("%s %0d,%0d cin%0d", s[0] ? "sub" : "add", iv[7:4], iv[3:0], rc),
                     s[0], rc, iv[7:4], iv[3:0], m[3:0], m[4], m[5]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
